reorder_buffer: RTL and testbench

//  In-order retirement queue of the out-of-order core.
//  - Allocates a rename tag ("nick") per dispatched instruction and drives it to the register file.
//  - Collects CDB results; commits the head entry's rd value to the register file.
//  - Resolves branch mispredictions at commit and raises the global clr flush with a redirect pc.

---
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : In-order retirement queue: nick allocation, CDB capture, commit
//            and misprediction flush. ROB_QUERY_EN adds two operand query ports.
// Revision : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int NICK_W    = 5,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NAME_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iDP_en,
    input  logic [NAME_W-1:0] iDP_rd_regnm,
    input  logic              iDP_is_store,
    input  logic              iDP_is_br,
    input  logic              iDP_pd,
    input  logic [ADDR_W-1:0] iDP_pc,
    output logic              oDP_full,
    output logic              oREG_nick_en,
    output logic [NAME_W-1:0] oREG_nick_regnm,
    output logic [NICK_W-1:0] oREG_nick,
    input  logic              iCDB_en,
    input  logic [NICK_W-1:0] iCDB_nick,
    input  logic [DATA_W-1:0] iCDB_dt,
    input  logic              iCDB_taken,
    input  logic [ADDR_W-1:0] iCDB_target,
`ifdef ROB_QUERY_EN
    input  logic [NICK_W-1:0] iQ_nick1,
    input  logic [NICK_W-1:0] iQ_nick2,
    output logic              oQ_rdy1,
    output logic              oQ_rdy2,
    output logic [DATA_W-1:0] oQ_dt1,
    output logic [DATA_W-1:0] oQ_dt2,
`endif
    output logic              oREG_en,
    output logic [NAME_W-1:0] oREG_rd_regnm,
    output logic [DATA_W-1:0] oREG_rd_dt,
    output logic [NICK_W-1:0] oREG_rd_nick,
    output logic              oLSB_commit_en,
    output logic [NICK_W-1:0] oLSB_commit_nick,
    output logic              clr,
    output logic [ADDR_W-1:0] oIF_pc
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = $clog2(ROB_DEPTH + 1);

    logic [ROB_DEPTH-1:0] busy_q, ready_q, st_q, br_q, pd_q, taken_q;
    logic [NAME_W-1:0]    rd_q  [ROB_DEPTH];
    logic [DATA_W-1:0]    dt_q  [ROB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q [ROB_DEPTH];
    logic [ADDR_W-1:0]    pc_q  [ROB_DEPTH];
    logic [IDX_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;

    logic              w_full, w_alloc, w_cdb_hit, w_commit, w_head_wr, w_mispred;
    logic [IDX_W-1:0]  w_cdb_idx;
    logic [NICK_W-1:0] w_head_nick;
    logic [ADDR_W-1:0] w_redirect;

    function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(ROB_DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    always_comb begin
        w_full          = (count_q == CNT_W'(ROB_DEPTH));
        w_alloc         = rdy & iDP_en & ~w_full;
        oDP_full        = w_full;
        oREG_nick_en    = w_alloc & ~iDP_is_store & (iDP_rd_regnm != '0);
        oREG_nick_regnm = iDP_rd_regnm;
        oREG_nick       = NICK_W'(tail_q) + NICK_W'(1);

        w_cdb_idx   = IDX_W'(iCDB_nick - NICK_W'(1));
        w_cdb_hit   = iCDB_en & (iCDB_nick != '0) & (iCDB_nick <= NICK_W'(ROB_DEPTH))
                      & busy_q[w_cdb_idx];
        // A result landing on the head this cycle defers its commit by one cycle.
        w_commit    = rdy & busy_q[head_q] & ready_q[head_q]
                      & ~(w_cdb_hit & (w_cdb_idx == head_q));
        w_head_wr   = ~st_q[head_q] & (rd_q[head_q] != '0);
        w_mispred   = w_commit & br_q[head_q] & (taken_q[head_q] != pd_q[head_q]);
        w_head_nick = NICK_W'(head_q) + NICK_W'(1);
        w_redirect  = taken_q[head_q] ? tgt_q[head_q] : pc_q[head_q] + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            busy_q           <= '0;
            ready_q          <= '0;
            oREG_en          <= 1'b0;
            oREG_rd_regnm    <= '0;
            oREG_rd_dt       <= '0;
            oREG_rd_nick     <= '0;
            oLSB_commit_en   <= 1'b0;
            oLSB_commit_nick <= '0;
            clr              <= 1'b0;
            oIF_pc           <= '0;
        end else if (!rdy) begin
            oREG_en          <= 1'b0;
            oREG_rd_regnm    <= '0;
            oREG_rd_dt       <= '0;
            oREG_rd_nick     <= '0;
            oLSB_commit_en   <= 1'b0;
            oLSB_commit_nick <= '0;
            clr              <= 1'b0;
            oIF_pc           <= '0;
        end else begin
            oREG_en          <= w_commit & w_head_wr;
            oREG_rd_regnm    <= w_commit ? rd_q[head_q] : '0;
            oREG_rd_dt       <= w_commit ? dt_q[head_q] : '0;
            oREG_rd_nick     <= w_commit ? w_head_nick : '0;
            oLSB_commit_en   <= w_commit & st_q[head_q];
            oLSB_commit_nick <= (w_commit & st_q[head_q]) ? w_head_nick : '0;
            clr              <= w_mispred;
            oIF_pc           <= w_mispred ? w_redirect : '0;

            if (w_cdb_hit) begin
                ready_q[w_cdb_idx] <= 1'b1;
                dt_q[w_cdb_idx]    <= iCDB_dt;
                taken_q[w_cdb_idx] <= iCDB_taken;
                tgt_q[w_cdb_idx]   <= iCDB_target;
            end
            if (w_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= inc_ptr(head_q);
            end
            if (w_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                rd_q[tail_q]    <= iDP_rd_regnm;
                st_q[tail_q]    <= iDP_is_store;
                br_q[tail_q]    <= iDP_is_br;
                pd_q[tail_q]    <= iDP_pd;
                pc_q[tail_q]    <= iDP_pc;
                tail_q          <= inc_ptr(tail_q);
            end
            if (w_alloc && !w_commit) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_alloc && w_commit) begin
                count_q <= count_q - CNT_W'(1);
            end
            // Flush wins over everything above, including this cycle's allocation.
            if (w_mispred) begin
                busy_q  <= '0;
                ready_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end
        end
    end

`ifdef ROB_QUERY_EN
    function automatic logic [DATA_W:0] query(input logic [NICK_W-1:0] n);
        logic [IDX_W-1:0] idx;
        logic [DATA_W:0]  res;
        idx = IDX_W'(n - NICK_W'(1));
        res = '0;
        if (n != '0 && n <= NICK_W'(ROB_DEPTH) && busy_q[idx]) begin
            if (ready_q[idx]) begin
                res = {1'b1, dt_q[idx]};
            end else if (iCDB_en && iCDB_nick == n) begin
                res = {1'b1, iCDB_dt};
            end
        end
        return res;
    endfunction

    always_comb begin
        {oQ_rdy1, oQ_dt1} = query(iQ_nick1);
        {oQ_rdy2, oQ_dt2} = query(iQ_nick2);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_reorder_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        iDP_en, iDP_is_store, iDP_is_br, iDP_pd;
    logic [4:0]  iDP_rd_regnm;
    logic [31:0] iDP_pc;
    logic        oDP_full, oREG_nick_en;
    logic [4:0]  oREG_nick_regnm, oREG_nick;
    logic        iCDB_en, iCDB_taken;
    logic [4:0]  iCDB_nick;
    logic [31:0] iCDB_dt, iCDB_target;
    logic        oREG_en, oLSB_commit_en, clr;
    logic [4:0]  oREG_rd_regnm, oREG_rd_nick, oLSB_commit_nick;
    logic [31:0] oREG_rd_dt, oIF_pc;
`ifdef ROB_QUERY_EN
    logic [4:0]  iQ_nick1, iQ_nick2;
    logic        oQ_rdy1, oQ_rdy2;
    logic [31:0] oQ_dt1, oQ_dt2;
`endif

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iDP_en(iDP_en), .iDP_rd_regnm(iDP_rd_regnm), .iDP_is_store(iDP_is_store),
        .iDP_is_br(iDP_is_br), .iDP_pd(iDP_pd), .iDP_pc(iDP_pc),
        .oDP_full(oDP_full), .oREG_nick_en(oREG_nick_en),
        .oREG_nick_regnm(oREG_nick_regnm), .oREG_nick(oREG_nick),
        .iCDB_en(iCDB_en), .iCDB_nick(iCDB_nick), .iCDB_dt(iCDB_dt),
        .iCDB_taken(iCDB_taken), .iCDB_target(iCDB_target),
`ifdef ROB_QUERY_EN
        .iQ_nick1(iQ_nick1), .iQ_nick2(iQ_nick2), .oQ_rdy1(oQ_rdy1), .oQ_rdy2(oQ_rdy2),
        .oQ_dt1(oQ_dt1), .oQ_dt2(oQ_dt2),
`endif
        .oREG_en(oREG_en), .oREG_rd_regnm(oREG_rd_regnm), .oREG_rd_dt(oREG_rd_dt),
        .oREG_rd_nick(oREG_rd_nick), .oLSB_commit_en(oLSB_commit_en),
        .oLSB_commit_nick(oLSB_commit_nick), .clr(clr), .oIF_pc(oIF_pc)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_reg_commits = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: queue of in-flight instructions ----------------
    typedef struct {
        logic [4:0]  nick;
        logic [4:0]  rd;
        logic        st, br, pd, rdy, tk;
        logic [31:0] pc, dt, tg;
    } ent_t;

    typedef struct {
        logic        d_en;
        logic [4:0]  rd;
        logic        st, br, pd;
        logic [31:0] pc;
        logic        c_en;
        logic [4:0]  c_nick;
        logic [31:0] c_dt;
        logic        c_tk;
        logic [31:0] c_tg;
        logic        r;
    } stim_t;

    ent_t mq[$];
    int   next_nick = 1;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        s.r = 1'b1;
        return s;
    endfunction

    task automatic set_idle();
        iDP_en = 0; iDP_rd_regnm = 0; iDP_is_store = 0; iDP_is_br = 0; iDP_pd = 0; iDP_pc = 0;
        iCDB_en = 0; iCDB_nick = 0; iCDB_dt = 0; iCDB_taken = 0; iCDB_target = 0; rdy = 1;
`ifdef ROB_QUERY_EN
        iQ_nick1 = 0; iQ_nick2 = 0;
`endif
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        mq.delete();
        next_nick = 1;
    endtask

`ifdef ROB_QUERY_EN
    function automatic logic [4:0] pick_nick();
        if (mq.size() > 0 && $urandom_range(0, 99) < 75) return mq[$urandom_range(0, mq.size() - 1)].nick;
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic chk_query(input string nm, input logic [4:0] n, input logic q_rdy,
                             input logic [31:0] q_dt, input stim_t s);
        logic        er;
        logic [31:0] ed;
        er = 0; ed = 0;
        foreach (mq[i]) begin
            if (mq[i].nick == n) begin
                if (mq[i].rdy) begin er = 1; ed = mq[i].dt; end
                else if (s.c_en && s.c_nick == n) begin er = 1; ed = s.c_dt; end
            end
        end
        chk({nm, "_rdy"}, q_rdy, er);
        if (er || n == 0) chk({nm, "_dt"}, q_dt, ed);
    endtask
`endif

    // One clock of stimulus; checks comb outputs before and registered outputs after the edge.
    task automatic cyc(input stim_t s);
        int   hit;
        logic full, alloc, commit, mis;
        ent_t h, e;
        iDP_en = s.d_en; iDP_rd_regnm = s.rd; iDP_is_store = s.st; iDP_is_br = s.br;
        iDP_pd = s.pd; iDP_pc = s.pc; iCDB_en = s.c_en; iCDB_nick = s.c_nick;
        iCDB_dt = s.c_dt; iCDB_taken = s.c_tk; iCDB_target = s.c_tg; rdy = s.r;
`ifdef ROB_QUERY_EN
        iQ_nick1 = pick_nick(); iQ_nick2 = pick_nick();
`endif
        #1;
        full  = (mq.size() == DEPTH);
        alloc = s.r && s.d_en && !full;
        chk("full", oDP_full, full);
        chk("nick_en", oREG_nick_en, alloc && !s.st && s.rd != 0);
        if (s.d_en) chk("nick", oREG_nick, next_nick);
        if (alloc) chk("nick_regnm", oREG_nick_regnm, s.rd);
`ifdef ROB_QUERY_EN
        chk_query("q1", iQ_nick1, oQ_rdy1, oQ_dt1, s);
        chk_query("q2", iQ_nick2, oQ_rdy2, oQ_dt2, s);
`endif
        hit = -1;
        if (s.c_en) foreach (mq[i]) if (mq[i].nick == s.c_nick) hit = i;
        commit = s.r && mq.size() > 0 && mq[0].rdy && hit != 0;
        h = '{default: 0};
        if (commit) h = mq[0];
        mis = commit && h.br && (h.tk != h.pd);

        @(posedge clk);
        #1;
        chk("reg_en", oREG_en, commit && !h.st && h.rd != 0);
        if (commit && !h.st && h.rd != 0) begin
            n_reg_commits++;
            chk("reg_rd", oREG_rd_regnm, h.rd);
            chk("reg_dt", oREG_rd_dt, h.dt);
            chk("reg_nick", oREG_rd_nick, h.nick);
        end
        chk("lsb_en", oLSB_commit_en, commit && h.st);
        if (commit && h.st) chk("lsb_nick", oLSB_commit_nick, h.nick);
        chk("clr", clr, mis);
        if (mis) chk("redirect_pc", oIF_pc, h.tk ? h.tg : h.pc + 32'd4);

        if (s.r) begin
            if (hit >= 0) begin
                e = mq[hit];
                e.rdy = 1; e.dt = s.c_dt; e.tk = s.c_tk; e.tg = s.c_tg;
                mq[hit] = e;
            end
            if (commit) void'(mq.pop_front());
            if (mis) begin
                mq.delete();
                next_nick = 1;
            end else if (alloc) begin
                e = '{nick: 5'(next_nick), rd: s.rd, st: s.st, br: s.br, pd: s.pd, rdy: 0,
                      tk: 0, pc: s.pc, dt: 0, tg: 0};
                mq.push_back(e);
                next_nick = next_nick % DEPTH + 1;
            end
        end
    endtask

    function automatic stim_t rand_stim(input int cdb_pct, input int br_pct);
        stim_t s;
        s = idle_stim();
        s.d_en = $urandom_range(0, 99) < 55;
        s.rd   = 5'($urandom_range(0, 31));
        s.st   = $urandom_range(0, 99) < 15;
        s.br   = !s.st && ($urandom_range(0, 99) < br_pct);
        s.pd   = 1'($urandom_range(0, 1));
        s.pc   = 32'($urandom_range(0, 4095)) << 2;
        s.c_en = $urandom_range(0, 99) < cdb_pct;
        if (mq.size() > 0 && $urandom_range(0, 99) < 80) s.c_nick = mq[$urandom_range(0, mq.size() - 1)].nick;
        else s.c_nick = 5'($urandom_range(0, 31));
        s.c_dt = $urandom;
        s.c_tk = 1'($urandom_range(0, 1));
        s.c_tg = 32'($urandom_range(0, 4095)) << 2;
        s.r    = $urandom_range(0, 99) < 93;
        return s;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        dp_en;
        logic [4:0]  rd;
        logic        st;
        logic        cdb_en;
        logic [4:0]  cdb_nick;
        logic [31:0] cdb_dt;
        logic        x_full, x_nen;
        logic [4:0]  x_nick;
        logic        x_ren;
        logic [4:0]  x_rd;
        logic [31:0] x_dt;
        logic [4:0]  x_rnick;
        logic        x_len;
        logic [4:0]  x_lnick;
    } vec_t;

    localparam int NV = 14;
    vec_t tv [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        stim_t s;
        int    wrap_start;

        tv[0]  = '{1, 5, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0,       0, 0, 0};
        tv[1]  = '{1, 6, 0, 0, 0, 0,       0, 1, 2, 0, 0, 0,       0, 0, 0};
        tv[2]  = '{1, 3, 1, 0, 0, 0,       0, 0, 3, 0, 0, 0,       0, 0, 0};
        tv[3]  = '{1, 0, 0, 0, 0, 0,       0, 0, 4, 0, 0, 0,       0, 0, 0};
        tv[4]  = '{0, 0, 0, 1, 2, 'hBB,    0, 0, 0, 0, 0, 0,       0, 0, 0};
        tv[5]  = '{0, 0, 0, 1, 1, 'hAA,    0, 0, 0, 0, 0, 0,       0, 0, 0};
        tv[6]  = '{0, 0, 0, 1, 3, 'h33,    0, 0, 0, 1, 5, 'hAA,    1, 0, 0};
        tv[7]  = '{0, 0, 0, 1, 4, 'h77,    0, 0, 0, 1, 6, 'hBB,    2, 0, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0,       0, 1, 3};
        tv[9]  = '{0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0,       0, 0, 0};
        tv[10] = '{1, 7, 0, 0, 0, 0,       0, 1, 5, 0, 0, 0,       0, 0, 0};
        tv[11] = '{0, 0, 0, 1, 5, 'h55,    0, 0, 0, 0, 0, 0,       0, 0, 0};
        tv[12] = '{0, 0, 0, 1, 5, 'h66,    0, 0, 0, 0, 0, 0,       0, 0, 0};
        tv[13] = '{0, 0, 0, 0, 0, 0,       0, 0, 0, 1, 7, 'h66,    5, 0, 0};

        // Reset values and first nick
        do_reset();
        chk("rst_full", oDP_full, 0);
        chk("rst_clr", clr, 0);
        chk("rst_reg_en", oREG_en, 0);
        chk("rst_lsb_en", oLSB_commit_en, 0);
        iDP_en = 1; iDP_rd_regnm = 1;
        #1;
        chk("rst_first_nick", oREG_nick, 1);
        chk("rst_first_nick_en", oREG_nick_en, 1);
        set_idle();
        #1;

        // In-order commit, store, rd=0 retire, CDB on the head in the commit cycle
        for (int i = 0; i < NV; i++) begin
            iDP_en = tv[i].dp_en; iDP_rd_regnm = tv[i].rd; iDP_is_store = tv[i].st;
            iCDB_en = tv[i].cdb_en; iCDB_nick = tv[i].cdb_nick; iCDB_dt = tv[i].cdb_dt;
            #1;
            chk($sformatf("tv%0d_full", i), oDP_full, tv[i].x_full);
            chk($sformatf("tv%0d_nick_en", i), oREG_nick_en, tv[i].x_nen);
            if (tv[i].dp_en) chk($sformatf("tv%0d_nick", i), oREG_nick, tv[i].x_nick);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_reg_en", i), oREG_en, tv[i].x_ren);
            if (tv[i].x_ren) begin
                chk($sformatf("tv%0d_reg_rd", i), oREG_rd_regnm, tv[i].x_rd);
                chk($sformatf("tv%0d_reg_dt", i), oREG_rd_dt, tv[i].x_dt);
                chk($sformatf("tv%0d_reg_nick", i), oREG_rd_nick, tv[i].x_rnick);
            end
            chk($sformatf("tv%0d_lsb_en", i), oLSB_commit_en, tv[i].x_len);
            if (tv[i].x_len) chk($sformatf("tv%0d_lsb_nick", i), oLSB_commit_nick, tv[i].x_lnick);
            chk($sformatf("tv%0d_clr", i), clr, 0);
        end
        set_idle();

        // Fill to full, ignored 17th dispatch, then drain one
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            s = idle_stim(); s.d_en = 1; s.rd = 5'(i);
            cyc(s);
        end
        chk("fill_full", oDP_full, 1);
        s = idle_stim(); s.d_en = 1; s.rd = 9;
        cyc(s);
        chk("fill_full_held", oDP_full, 1);
        s = idle_stim(); s.c_en = 1; s.c_nick = 1; s.c_dt = 32'h1234;
        cyc(s);
        cyc(idle_stim());
        chk("fill_full_drained", oDP_full, 0);

        // Misprediction: taken branch predicted not-taken, with younger entries and a discarded alloc
        do_reset();
        s = idle_stim(); s.d_en = 1; s.br = 1; s.pd = 0; s.pc = 32'h100; cyc(s);
        for (int i = 1; i <= 3; i++) begin
            s = idle_stim(); s.d_en = 1; s.rd = 5'(i); cyc(s);
        end
        s = idle_stim(); s.c_en = 1; s.c_nick = 1; s.c_tk = 1; s.c_tg = 32'h200; cyc(s);
        s = idle_stim(); s.d_en = 1; s.rd = 4; s.c_en = 1; s.c_nick = 3; cyc(s);
        chk("mis_clr", clr, 1);
        chk("mis_pc", oIF_pc, 32'h200);
        cyc(idle_stim());
        chk("mis_clr_pulse", clr, 0);
        chk("mis_full", oDP_full, 0);
        iDP_en = 1; iDP_rd_regnm = 2;
        #1;
        chk("mis_next_nick", oREG_nick, 1);

        // JALR-style: predicted taken, resolved not-taken, with link write
        s = idle_stim(); s.d_en = 1; s.rd = 1; s.br = 1; s.pd = 1; s.pc = 32'h300; cyc(s);
        s = idle_stim(); s.c_en = 1; s.c_nick = 1; s.c_dt = 32'h304; s.c_tk = 0; cyc(s);
        cyc(idle_stim());
        chk("nt_pc", oIF_pc, 32'h304);
        chk("nt_link", oREG_en, 1);

        // Reset beats a pending flush
        do_reset();
        s = idle_stim(); s.d_en = 1; s.br = 1; s.pd = 0; s.pc = 32'h40; cyc(s);
        s = idle_stim(); s.c_en = 1; s.c_nick = 1; s.c_tk = 1; s.c_tg = 32'h80; cyc(s);
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_over_clr", clr, 0);
        chk("rst_over_full", oDP_full, 0);
        do_reset();

        // Full-throughput wrap: dispatch every cycle, complete the previous one
        wrap_start = n_reg_commits;
        for (int k = 0; k < 40; k++) begin
            s = idle_stim(); s.d_en = 1; s.rd = 5'(k % 31 + 1);
            if (mq.size() > 0) begin
                s.c_en = 1; s.c_nick = mq[mq.size() - 1].nick; s.c_dt = 32'(k * 3 + 1);
            end
            cyc(s);
        end
        chk("wrap_commits", n_reg_commits - wrap_start, 38);

        // Random traffic: mixed, then CDB-starved to reach full
        do_reset();
        for (int k = 0; k < 1500; k++) cyc(rand_stim(60, 12));
        for (int k = 0; k < 400; k++) cyc(rand_stim(15, 3));
        for (int k = 0; k < 300; k++) cyc(rand_stim(80, 20));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
